// File: rtl/seq_monitor.sv
// seq_monitor: locks onto the 8-code custom counter sequence, tracks the position,
// flags broken transitions and counts completed cycles. Purely an observer.
module seq_monitor #(
  parameter int unsigned LOCK_N = 4,  // correct transitions needed to lock, 1..15
  parameter int unsigned CNT_W  = 8   // width of err_cnt and cycle_cnt
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [3:0]       q,
  output logic             locked,
  output logic [2:0]       idx,
  output logic             err,
  output logic             illegal,
  output logic             wrap,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    StUnlocked,
    StAcquire,
    StLocked
  } state_e;

  localparam logic [3:0] LockTarget = 4'(LOCK_N);

  state_e     state_q;
  logic [3:0] acq_q;

  logic       q_legal;
  logic [2:0] q_idx;
  logic [2:0] idx_succ;
  logic [3:0] acq_inc;
  logic       step_ok;

  // Map the sampled code to its sequence position; 8 codes are not part of the cycle.
  always_comb begin
    q_legal = 1'b1;
    q_idx   = 3'd0;
    case (q)
      4'b0000: q_idx = 3'd0;
      4'b1101: q_idx = 3'd1;
      4'b1011: q_idx = 3'd2;
      4'b1001: q_idx = 3'd3;
      4'b0110: q_idx = 3'd4;
      4'b1100: q_idx = 3'd5;
      4'b0011: q_idx = 3'd6;
      4'b1111: q_idx = 3'd7;
      default: q_legal = 1'b0;
    endcase
  end

  // Successor wraps 7 -> 0 naturally in 3 bits; a repeated code is never a successor.
  assign idx_succ = idx + 3'd1;
  assign acq_inc  = acq_q + 4'd1;
  assign step_ok  = q_legal && (q_idx == idx_succ);

  // Lock FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= StUnlocked;
      acq_q     <= 4'd0;
      idx       <= 3'd0;
      locked    <= 1'b0;
      err       <= 1'b0;
      illegal   <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
      cycle_cnt <= '0;
    end else begin
      err     <= 1'b0;
      illegal <= 1'b0;
      wrap    <= 1'b0;
      if (en) begin
        case (state_q)
          StUnlocked: begin
            if (q_legal) begin
              idx     <= q_idx;
              acq_q   <= 4'd0;
              state_q <= StAcquire;
            end else begin
              illegal <= 1'b1;
            end
          end
          StAcquire: begin
            if (step_ok) begin
              idx   <= idx_succ;
              acq_q <= acq_inc;
              // The locking transition itself never reports a wrap.
              if (acq_inc == LockTarget) begin
                state_q <= StLocked;
                locked  <= 1'b1;
              end
            end else if (q_legal) begin
              idx   <= q_idx;
              acq_q <= 4'd0;
            end else begin
              state_q <= StUnlocked;
              illegal <= 1'b1;
            end
          end
          StLocked: begin
            if (step_ok) begin
              idx <= idx_succ;
              if (idx == 3'd7) begin
                wrap      <= 1'b1;
                cycle_cnt <= cycle_cnt + CNT_W'(1);
              end
            end else begin
              err    <= 1'b1;
              locked <= 1'b0;
              if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
              if (q_legal) begin
                idx     <= q_idx;
                acq_q   <= 4'd0;
                state_q <= StAcquire;
              end else begin
                state_q <= StUnlocked;
                illegal <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= StUnlocked;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_monitor.sv
// Randomized self-checking bench for seq_monitor against a run-length reference model.
module tb_seq_monitor;

  localparam int LOCK_N = 4;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en  = 1'b0;
  logic [3:0] q   = 4'd0;

  logic       locked, err, illegal, wrap;
  logic [2:0] idx;
  logic [7:0] err_cnt, cycle_cnt;
  logic       locked2, err2, illegal2, wrap2;
  logic [2:0] idx2;
  logic [1:0] err_cnt2, cycle_cnt2;

  seq_monitor #(.LOCK_N(LOCK_N), .CNT_W(8)) u_dut (
    .clk(clk), .clr(clr), .en(en), .q(q), .locked(locked), .idx(idx), .err(err),
    .illegal(illegal), .wrap(wrap), .err_cnt(err_cnt), .cycle_cnt(cycle_cnt)
  );

  seq_monitor #(.LOCK_N(LOCK_N), .CNT_W(2)) u_dut2 (
    .clk(clk), .clr(clr), .en(en), .q(q), .locked(locked2), .idx(idx2), .err(err2),
    .illegal(illegal2), .wrap(wrap2), .err_cnt(err_cnt2), .cycle_cnt(cycle_cnt2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] codes [8] = '{4'h0, 4'hD, 4'hB, 4'h9, 4'h6, 4'hC, 4'h3, 4'hF};
  int gen_pos = 7;

  // Reference model: position of last legal code and length of the current correct run.
  int         m_prev, m_run, m_ec, m_cc, m_ec2, m_cc2;
  logic [2:0] m_idx;
  logic       m_locked, m_err, m_ill, m_wrap;

  function automatic int idx_of(input logic [3:0] c);
    for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [26:0] obs();
    return {locked, idx, err, illegal, wrap, err_cnt, cycle_cnt, err_cnt2, cycle_cnt2};
  endfunction

  function automatic logic [26:0] expv();
    return {m_locked, m_idx, m_err, m_ill, m_wrap, 8'(m_ec), 8'(m_cc), 2'(m_ec2), 2'(m_cc2)};
  endfunction

  task automatic model_reset();
    m_prev = -1; m_run = 0; m_idx = 3'd0; m_locked = 1'b0;
    m_err = 1'b0; m_ill = 1'b0; m_wrap = 1'b0;
    m_ec = 0; m_cc = 0; m_ec2 = 0; m_cc2 = 0;
  endtask

  task automatic model_err();
    m_err = 1'b1;
    if (m_ec < 255) m_ec++;
    if (m_ec2 < 3) m_ec2++;
  endtask

  task automatic model(input logic e, input logic [3:0] c);
    int k;
    bit was_locked;
    m_err = 1'b0; m_ill = 1'b0; m_wrap = 1'b0;
    if (e) begin
      k = idx_of(c);
      was_locked = (m_run >= LOCK_N);
      if (k < 0) begin
        m_ill = 1'b1;
        if (was_locked) model_err();
        m_prev = -1;
        m_run = 0;
      end else if (m_prev >= 0 && k == (m_prev + 1) % 8) begin
        if (was_locked && m_prev == 7) begin
          m_wrap = 1'b1;
          m_cc = (m_cc + 1) % 256;
          m_cc2 = (m_cc2 + 1) % 4;
        end
        m_run++;
        m_prev = k;
        m_idx = 3'(k);
      end else begin
        if (was_locked) model_err();
        m_run = 0;
        m_prev = k;
        m_idx = 3'(k);
      end
      m_locked = (m_run >= LOCK_N);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] c);
    @(negedge clk);
    en = e;
    q = c;
    @(posedge clk);
    model(e, c);
    #1;
  endtask

  task automatic next(input logic e);
    step(e, codes[(gen_pos + 1) % 8]);
    if (e) gen_pos = (gen_pos + 1) % 8;
  endtask

  task automatic step_code(input logic [3:0] c);
    step(1'b1, c);
    if (idx_of(c) >= 0) gen_pos = idx_of(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    #1 clr = 1'b0;
    model_reset();
    #1 clr = 1'b1;
    gen_pos = 7;
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    if (obs() !== 27'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", obs());
    end
    checks++;
    #4 clr = 1'b1;
    step(1'b0, 4'h0);
    if (obs() !== expv()) begin
      errors++; $display("FAIL reset_idle: got %h want %h", obs(), expv());
    end
    checks++;
  endtask

  task automatic test_clean_sequence();
    for (int i = 0; i < 20; i++) begin
      next(1'b1);
      if (obs() !== expv()) begin
        errors++; $display("FAIL clean step%0d: got %h want %h", i, obs(), expv());
      end
      checks++;
      if (i == 3 && locked !== 1'b0) begin
        errors++; $display("FAIL clean_early_lock: got %b want 0", locked);
      end
      if (i == 4 && locked !== 1'b1) begin
        errors++; $display("FAIL clean_lock_5th: got %b want 1", locked);
      end
      if (i == 8 && (wrap !== 1'b1 || cycle_cnt !== 8'd1)) begin
        errors++; $display("FAIL clean_first_wrap: got wrap=%b cnt=%0d want 1/1", wrap, cycle_cnt);
      end
      if (i == 3 || i == 4 || i == 8) checks++;
    end
  endtask

  task automatic test_skip();
    step_code(4'b0110);
    if (obs() !== expv()) begin
      errors++; $display("FAIL skip_pre: got %h want %h", obs(), expv());
    end
    checks++;
    step_code(4'b1011);
    if ({err, locked, idx, err_cnt} !== {1'b1, 1'b0, 3'd2, 8'd1}) begin
      errors++; $display("FAIL skip_err: got %h want %h", {err, locked, idx, err_cnt},
                         {1'b1, 1'b0, 3'd2, 8'd1});
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      next(1'b1);
      if (obs() !== expv() || locked !== (i == 3)) begin
        errors++; $display("FAIL skip_relock%0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
  endtask

  task automatic test_illegal_locked();
    step(1'b1, 4'b1010);
    if ({err, illegal, locked} !== 3'b110 || obs() !== expv()) begin
      errors++; $display("FAIL illegal_locked: got %h want %h", obs(), expv());
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      next(1'b1);
      if (obs() !== expv() || locked !== (i == 4)) begin
        errors++; $display("FAIL illegal_reacq%0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
  endtask

  task automatic test_en_toggle();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) next(1'b1);
      else step(1'b0, 4'($urandom));
      if (obs() !== expv()) begin
        errors++; $display("FAIL en_toggle%0d: got %h want %h", i, obs(), expv());
      end
      checks++;
      if (i % 2 == 1 && {err, illegal, wrap} !== 3'b000) begin
        errors++; $display("FAIL en_idle_pulse%0d: got %b want 000", i, {err, illegal, wrap});
      end
      if (i % 2 == 1) checks++;
    end
    if (cycle_cnt !== 8'd2) begin
      errors++; $display("FAIL en_toggle_cycles: got %0d want 2", cycle_cnt);
    end
    checks++;
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 5; r++) begin
      step(1'b1, codes[gen_pos]);  // repeated code breaks the lock
      if (obs() !== expv()) begin
        errors++; $display("FAIL sat_err%0d: got %h want %h", r, obs(), expv());
      end
      checks++;
      for (int i = 0; i < 4; i++) next(1'b1);
    end
    if (err_cnt !== 8'd5 || err_cnt2 !== 2'd3) begin
      errors++; $display("FAIL sat_counts: got %0d/%0d want 5/3", err_cnt, err_cnt2);
    end
    checks++;
  endtask

  task automatic test_cycle_wrap();
    do_reset();
    for (int i = 0; i < 41; i++) begin
      next(1'b1);
      if (obs() !== expv()) begin
        errors++; $display("FAIL cycles%0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
    if (cycle_cnt !== 8'd5 || cycle_cnt2 !== 2'd1) begin
      errors++; $display("FAIL cycle_mod: got %0d/%0d want 5/1", cycle_cnt, cycle_cnt2);
    end
    checks++;
  endtask

  task automatic test_async_clear();
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int i = 0; i < (pass == 0 ? 3 : 12); i++) next(1'b1);
      #2 clr = 1'b0;  // between edges
      model_reset();
      #1;
      if (obs() !== 27'd0) begin
        errors++; $display("FAIL async_clear%0d: got %h want 0", pass, obs());
      end
      checks++;
      #2 clr = 1'b1;
      gen_pos = 7;
      for (int i = 0; i < 5; i++) begin
        next(1'b1);
        if (obs() !== expv() || locked !== (i == 4)) begin
          errors++; $display("FAIL async_relock%0d_%0d: got %h want %h", pass, i, obs(), expv());
        end
        checks++;
      end
    end
  endtask

  task automatic test_random();
    logic       e;
    logic [3:0] c;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) < 16) begin
        next(e);
      end else begin
        c = 4'($urandom);
        step(e, c);
        if (e && idx_of(c) >= 0) gen_pos = idx_of(c);
      end
      if (obs() !== expv()) begin
        errors++; $display("FAIL random%0d: got %h want %h", i, obs(), expv());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_sequence();
    test_skip();
    test_illegal_locked();
    test_en_toggle();
    test_saturation();
    test_cycle_wrap();
    test_async_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
